// File: rtl/bcd_score_keeper.sv
// BCD score counter with high-score register, play/over FSM and seg7 display drive.
// Scores rising edges of the OR of an event bus, saturating at all 9s.
module bcd_score_keeper #(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned EVENT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [EVENT_W-1:0]    events,
  input  logic [3:0]            step,
  input  logic                  gameover,
  input  logic                  start,
  input  logic                  show_high,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   high_bcd,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  playing,
  output logic                  new_record,
  output logic                  saturated
);

  typedef enum logic [0:0] {StPlay, StOver} state_e;

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] score_q, score_d;
  logic [4*DIGITS-1:0] high_q, high_d;
  logic [4*DIGITS-1:0] sum;
  logic                prev_q;
  logic                new_record_q, new_record_d;
  logic                saturated_q, saturated_d;
  logic                ev_any, hit, sum_ovf, carry;
  logic [3:0]          step_c;
  logic [4:0]          acc;

  assign ev_any = |events;
  assign hit    = ev_any & ~prev_q;
  assign step_c = (step > 4'd9) ? 4'd9 : step;

  // Decimal ripple add of the clamped step into digit 0; carry-out means overflow.
  always_comb begin
    carry = 1'b0;
    acc   = '0;
    sum   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      acc = {1'b0, score_q[4*i +: 4]} + {4'b0, carry};
      if (i == 0) acc = acc + {1'b0, step_c};
      if (acc > 5'd9) begin
        acc   = acc - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i +: 4] = acc[3:0];
    end
    sum_ovf = carry;
  end

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    high_d       = high_q;
    new_record_d = new_record_q;
    saturated_d  = saturated_q;
    case (state_q)
      StPlay: begin
        if (gameover) begin
          state_d = StOver;
          // Packed BCD orders the same as unsigned binary.
          if (score_q > high_q) begin
            high_d       = score_q;
            new_record_d = 1'b1;
          end else begin
            new_record_d = 1'b0;
          end
        end else if (hit) begin
          if (sum_ovf) begin
            score_d     = {DIGITS{4'h9}};
            saturated_d = 1'b1;
          end else begin
            score_d = sum;
          end
        end
      end
      StOver: begin
        if (start) begin
          state_d     = StPlay;
          score_d     = '0;
          saturated_d = 1'b0;
        end
      end
      default: state_d = StPlay;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StPlay;
      score_q      <= '0;
      high_q       <= '0;
      prev_q       <= 1'b0;
      new_record_q <= 1'b0;
      saturated_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      high_q       <= high_d;
      prev_q       <= ev_any;
      new_record_q <= new_record_d;
      saturated_q  <= saturated_d;
    end
  end

  // Active-high segments, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  always_comb begin
    hex = '0;
    for (int i = 0; i < DIGITS; i++) begin
      hex[7*i +: 7] = seg7(show_high ? high_q[4*i +: 4] : score_q[4*i +: 4]);
    end
  end

  assign score_bcd  = score_q;
  assign high_bcd   = high_q;
  assign playing    = (state_q == StPlay);
  assign new_record = new_record_q;
  assign saturated  = saturated_q;

endmodule

// File: tb/tb_bcd_score_keeper.sv
// Table-driven bench for bcd_score_keeper: one record per clock cycle with
// hand-computed expected registers; hex expectation derived from a seg7 table.
module tb_bcd_score_keeper;

  localparam int unsigned DIGITS  = 2;
  localparam int unsigned EVENT_W = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [EVENT_W-1:0]  events;
  logic [3:0]          step;
  logic                gameover, start, show_high;
  logic [4*DIGITS-1:0] score_bcd, high_bcd;
  logic [7*DIGITS-1:0] hex;
  logic                playing, new_record, saturated;

  bcd_score_keeper #(.DIGITS(DIGITS), .EVENT_W(EVENT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .events     (events),
    .step       (step),
    .gameover   (gameover),
    .start      (start),
    .show_high  (show_high),
    .score_bcd  (score_bcd),
    .high_bcd   (high_bcd),
    .hex        (hex),
    .playing    (playing),
    .new_record (new_record),
    .saturated  (saturated)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [15:0] ev;
    logic [3:0]  st;
    logic        go, sta, sh;
    logic [7:0]  es, eh;
    logic        ep, enr, esat;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;
  logic done   = 1'b0;

  task automatic add(input logic r, input logic [15:0] ev, input logic [3:0] st,
                     input logic go, input logic sta, input logic sh,
                     input logic [7:0] es, input logic [7:0] eh,
                     input logic ep, input logic enr, input logic esat);
    vec_t v;
    v.r = r; v.ev = ev; v.st = st; v.go = go; v.sta = sta; v.sh = sh;
    v.es = es; v.eh = eh; v.ep = ep; v.enr = enr; v.esat = esat;
    vq.push_back(v);
  endtask

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'h3F; 4'd1: seg = 7'h06; 4'd2: seg = 7'h5B; 4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66; 4'd5: seg = 7'h6D; 4'd6: seg = 7'h7D; 4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F; 4'd9: seg = 7'h6F; default: seg = 7'h00;
    endcase
  endfunction

  logic [7:0] cnt_exp [12];

  initial begin
    #100000;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: vector table did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    cnt_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 8'h12};

    rst = 1'b1; events = '0; step = 4'd3; gameover = 1'b0; start = 1'b1; show_high = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (score_bcd !== 8'h00 || high_bcd !== 8'h00 || playing !== 1'b1 ||
        new_record !== 1'b0 || saturated !== 1'b0 || hex !== {seg(4'd0), seg(4'd0)}) begin
      errors++;
      $display("FAIL reset: score=%h high=%h play=%b nr=%b sat=%b hex=%h",
               score_bcd, high_bcd, playing, new_record, saturated, hex);
    end

    // r ev st go sta sh | score high play nr sat
    add(1, 16'h0, 4'd0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    // 12 single-cycle pulses at step 1
    for (int k = 0; k < 12; k++) begin
      add(0, 16'h0001, 4'd1, 0, 0, 0, cnt_exp[k], 8'h00, 1, 0, 0);
      add(0, 16'h0000, 4'd1, 0, 0, 0, cnt_exp[k], 8'h00, 1, 0, 0);
    end
    // Held event counts once
    add(1, 16'h0, 4'd1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    for (int k = 0; k < 10; k++) add(0, 16'h8000, 4'd1, 0, 0, 0, 8'h01, 8'h00, 1, 0, 0);
    add(0, 16'h0000, 4'd4, 0, 0, 0, 8'h01, 8'h00, 1, 0, 0);
    add(0, 16'h8000, 4'd4, 0, 0, 0, 8'h05, 8'h00, 1, 0, 0);
    add(0, 16'h0000, 4'hF, 0, 0, 0, 8'h05, 8'h00, 1, 0, 0);
    add(0, 16'h0100, 4'hF, 0, 0, 0, 8'h14, 8'h00, 1, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 0, 8'h14, 8'h00, 1, 0, 0);
    add(0, 16'h0002, 4'd0, 0, 0, 0, 8'h14, 8'h00, 1, 0, 0);
    add(0, 16'h0000, 4'd9, 0, 0, 0, 8'h14, 8'h00, 1, 0, 0);
    // Climb to 97 then saturate
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h23, 8'h00, 1, 0, 0);
    add(0, 16'h0000, 4'd9, 0, 0, 0, 8'h23, 8'h00, 1, 0, 0);
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h32, 8'h00, 1, 0, 0);
    add(0, 16'h0000, 4'd9, 0, 0, 0, 8'h32, 8'h00, 1, 0, 0);
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h41, 8'h00, 1, 0, 0);
    add(0, 16'h0000, 4'd9, 0, 0, 0, 8'h41, 8'h00, 1, 0, 0);
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h50, 8'h00, 1, 0, 0);
    add(0, 16'h0000, 4'd9, 0, 0, 0, 8'h50, 8'h00, 1, 0, 0);
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h59, 8'h00, 1, 0, 0);
    add(0, 16'h0000, 4'd9, 0, 0, 0, 8'h59, 8'h00, 1, 0, 0);
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h68, 8'h00, 1, 0, 0);
    add(0, 16'h0000, 4'd9, 0, 0, 0, 8'h68, 8'h00, 1, 0, 0);
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h77, 8'h00, 1, 0, 0);
    add(0, 16'h0000, 4'd9, 0, 0, 0, 8'h77, 8'h00, 1, 0, 0);
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h86, 8'h00, 1, 0, 0);
    add(0, 16'h0000, 4'd9, 0, 0, 0, 8'h86, 8'h00, 1, 0, 0);
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h95, 8'h00, 1, 0, 0);
    add(0, 16'h0000, 4'd2, 0, 0, 0, 8'h95, 8'h00, 1, 0, 0);
    add(0, 16'h0001, 4'd2, 0, 0, 0, 8'h97, 8'h00, 1, 0, 0);
    add(0, 16'h0000, 4'd5, 0, 0, 0, 8'h97, 8'h00, 1, 0, 0);
    add(0, 16'h0001, 4'd5, 0, 0, 0, 8'h99, 8'h00, 1, 0, 1);
    add(0, 16'h0000, 4'd1, 0, 0, 0, 8'h99, 8'h00, 1, 0, 1);
    add(0, 16'h0001, 4'd1, 0, 0, 0, 8'h99, 8'h00, 1, 0, 1);
    add(0, 16'h0000, 4'd1, 0, 0, 0, 8'h99, 8'h00, 1, 0, 1);
    // Reach 21, gameover wins over a same-cycle hit
    add(1, 16'h0, 4'd9, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h09, 8'h00, 1, 0, 0);
    add(0, 16'h0000, 4'd9, 0, 0, 0, 8'h09, 8'h00, 1, 0, 0);
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h18, 8'h00, 1, 0, 0);
    add(0, 16'h0000, 4'd3, 0, 0, 0, 8'h18, 8'h00, 1, 0, 0);
    add(0, 16'h0001, 4'd3, 0, 0, 0, 8'h21, 8'h00, 1, 0, 0);
    add(0, 16'h0000, 4'd3, 0, 0, 0, 8'h21, 8'h00, 1, 0, 0);
    add(0, 16'h0001, 4'd3, 1, 0, 0, 8'h21, 8'h21, 0, 1, 0);
    add(0, 16'h0000, 4'd3, 0, 0, 0, 8'h21, 8'h21, 0, 1, 0);
    add(0, 16'h0001, 4'd3, 0, 0, 0, 8'h21, 8'h21, 0, 1, 0);
    add(0, 16'h0000, 4'd3, 0, 0, 0, 8'h21, 8'h21, 0, 1, 0);
    // Restart, lower game, display high score
    add(0, 16'h0000, 4'd7, 0, 1, 0, 8'h00, 8'h21, 1, 1, 0);
    add(0, 16'h0001, 4'd7, 0, 0, 0, 8'h07, 8'h21, 1, 1, 0);
    add(0, 16'h0000, 4'd7, 1, 0, 0, 8'h07, 8'h21, 0, 0, 0);
    add(0, 16'h0000, 4'd7, 0, 0, 1, 8'h07, 8'h21, 0, 0, 0);
    // Build high 50, then a 33 game and reset
    add(0, 16'h0000, 4'd9, 0, 1, 0, 8'h00, 8'h21, 1, 0, 0);
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h09, 8'h21, 1, 0, 0);
    add(0, 16'h0000, 4'd9, 0, 0, 0, 8'h09, 8'h21, 1, 0, 0);
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h18, 8'h21, 1, 0, 0);
    add(0, 16'h0000, 4'd9, 0, 0, 0, 8'h18, 8'h21, 1, 0, 0);
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h27, 8'h21, 1, 0, 0);
    add(0, 16'h0000, 4'd9, 0, 0, 0, 8'h27, 8'h21, 1, 0, 0);
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h36, 8'h21, 1, 0, 0);
    add(0, 16'h0000, 4'd9, 0, 0, 0, 8'h36, 8'h21, 1, 0, 0);
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h45, 8'h21, 1, 0, 0);
    add(0, 16'h0000, 4'd5, 0, 0, 0, 8'h45, 8'h21, 1, 0, 0);
    add(0, 16'h0001, 4'd5, 0, 0, 0, 8'h50, 8'h21, 1, 0, 0);
    add(0, 16'h0000, 4'd5, 1, 0, 1, 8'h50, 8'h50, 0, 1, 0);
    add(0, 16'h0000, 4'd9, 0, 1, 0, 8'h00, 8'h50, 1, 1, 0);
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h09, 8'h50, 1, 1, 0);
    add(0, 16'h0000, 4'd9, 0, 0, 0, 8'h09, 8'h50, 1, 1, 0);
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h18, 8'h50, 1, 1, 0);
    add(0, 16'h0000, 4'd9, 0, 0, 0, 8'h18, 8'h50, 1, 1, 0);
    add(0, 16'h0001, 4'd9, 0, 0, 0, 8'h27, 8'h50, 1, 1, 0);
    add(0, 16'h0000, 4'd6, 0, 0, 0, 8'h27, 8'h50, 1, 1, 0);
    add(0, 16'h0001, 4'd6, 0, 0, 0, 8'h33, 8'h50, 1, 1, 0);
    add(0, 16'h0000, 4'd6, 0, 0, 0, 8'h33, 8'h50, 1, 1, 0);
    add(1, 16'h0001, 4'd6, 1, 1, 0, 8'h00, 8'h00, 1, 0, 0);
    // start+gameover in OVER: one PLAY cycle then OVER again with score 0
    add(0, 16'h0000, 4'd1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    add(0, 16'h0001, 4'd1, 1, 1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 16'h0001, 4'd1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    // Event held across restart does not count
    add(0, 16'h0001, 4'd1, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 16'h0001, 4'd1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 16'h0000, 4'd1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 16'h0001, 4'd1, 0, 0, 0, 8'h01, 8'h00, 1, 0, 0);

    foreach (vq[n]) begin
      logic [7:0]  shown;
      logic [13:0] ehex;
      rst = vq[n].r; events = vq[n].ev; step = vq[n].st;
      gameover = vq[n].go; start = vq[n].sta; show_high = vq[n].sh;
      @(posedge clk);
      #1;
      shown = vq[n].sh ? vq[n].eh : vq[n].es;
      ehex  = {seg(shown[7:4]), seg(shown[3:0])};
      checks++;
      if (score_bcd !== vq[n].es || high_bcd !== vq[n].eh || playing !== vq[n].ep ||
          new_record !== vq[n].enr || saturated !== vq[n].esat || hex !== ehex) begin
        errors++;
        $display("FAIL vec%0d: got score=%h high=%h play=%b nr=%b sat=%b hex=%h; want score=%h high=%h play=%b nr=%b sat=%b hex=%h",
                 n, score_bcd, high_bcd, playing, new_record, saturated, hex,
                 vq[n].es, vq[n].eh, vq[n].ep, vq[n].enr, vq[n].esat, ehex);
      end
    end

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_score_keeper.md
Name: bcd_score_keeper

Overview:
- Multi-digit BCD game score counter with a high-score register and a play/over state machine.
- Counts rising edges of an event bus (any bit set), e.g. a column-hit bus from the game field, adding a per-event BCD step.
- Freezes on game over, latches the high score and restarts on a start pulse.
- Drives one seven-segment digit per BCD digit through the team's existing seg7 decoder; sits between the game logic and the HEX displays.

Parameters:
- DIGITS, 2, number of BCD digits in the score and high score (1..6).
- EVENT_W, 16, width of the event input bus.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- events  input  EVENT_W  scoring event bus; a scoring event is a 0->1 transition of its OR-reduction.
- step  input  4  BCD points per event; values above 9 are clamped to 9.
- gameover  input  1  level; ends play.
- start  input  1  level; starts a new game from OVER.
- show_high  input  1  1 = displays show the high score; 0 = displays show the current score.
- score_bcd  output  4*DIGITS  current score; digit i occupies bits [4i+3:4i], digit 0 is least significant.
- high_bcd  output  4*DIGITS  high score, same layout as score_bcd.
- hex  output  7*DIGITS  seg7 pattern per digit; digit i occupies bits [7i+6:7i].
- playing  output  1  1 in state PLAY.
- new_record  output  1  set when the last game beat the high score.
- saturated  output  1  set when the score clamped to all 9s.

Behaviour:
- Reset state: PLAY; score = 0, high = 0, prev = 0, new_record = 0, saturated = 0, playing = 1. Reset overrides all other inputs.
- hit = |events & ~prev, where prev is a register holding |events from the previous cycle.
- PLAY, priority order:
  - gameover = 1: move to OVER. The score holds and any hit in the same cycle is ignored. If score > high (BCD compares as unsigned binary), then high <= score and new_record <= 1; otherwise new_record <= 0.
  - else if hit: score <= score + min(step, 9) in BCD with carry rippled across all DIGITS digits. Latency is one cycle, so score_bcd shows the new value after the clock edge where hit is true.
  - If the true sum exceeds 10^DIGITS - 1: score <= all 9s and saturated <= 1.
  - step = 0 with a hit leaves the score unchanged; this is not an error.
  - Holding events high counts exactly once. Events must return to 0 for one cycle before the next count.
- prev updates every cycle in every state: prev <= |events.
- OVER:
  - score, high and saturated hold; hits are ignored.
  - start = 1: move to PLAY and clear score and saturated. high and new_record are kept.
  - start and gameover both 1 in OVER: start wins. gameover is then re-sampled in PLAY on the next cycle, so a held gameover re-enters OVER immediately. In that re-entry score = 0, so new_record <= 0 and high is unchanged.
  - An event held across the restart does not count, because prev is already 1.
- start in PLAY is ignored.
- Display path is combinational from registers: hex digit i = seg7(show_high ? high digit i : score digit i). The seg7 polarity and encoding are those of the existing decoder.
- playing = (state == PLAY).
- All outputs are registered except hex and playing, which are decoded from registers.
- Digits never hold values above 9.

Test Plan:
- Reset, step = 1, pulse events = 16'h0001 (one cycle high, one cycle low) 12 times -> score_bcd = 8'h12; hex shows "1" and "2".
- events held at 16'h8000 for 10 cycles -> exactly one count. step = 4'hF then treated as 9: score 8'h05 plus one hit -> 8'h14.
- DIGITS = 2, score 8'h97, step = 5 hit -> score_bcd = 8'h99, saturated = 1. Further hits leave it unchanged.
- Score 8'h21, gameover = 1 in the same cycle as a hit -> score stays 8'h21, playing = 0, high_bcd = 8'h21, new_record = 1. Hits in OVER are ignored.
- start = 1 -> score 0, high 8'h21 kept. Play to 8'h07, then gameover -> high stays 8'h21, new_record = 0. show_high = 1 -> hex shows "21".
- rst asserted mid-game with score 8'h33 and high 8'h50 -> all cleared next cycle. start and gameover both held in OVER -> PLAY for one cycle, then OVER with score 0.
